// File: rtl/mips_pkg.sv
// Shared opcodes, FSM encoding and byte-enable constants for the MIPS memory stage.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dm_state_t;

  typedef enum logic [2:0] {
    LK_B  = 3'd0,
    LK_BU = 3'd1,
    LK_H  = 3'd2,
    LK_HU = 3'd3,
    LK_W  = 3'd4
  } load_kind_t;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;

endpackage

// File: rtl/dm_ext.sv
// Little-endian byte/half selection and sign/zero extension of a loaded word.
module dm_ext
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  load_kind_t  kind,
  output logic [31:0] ext
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = rdata[7:0];
    case (addr)
      2'd0: sel_byte = rdata[7:0];
      2'd1: sel_byte = rdata[15:8];
      2'd2: sel_byte = rdata[23:16];
      2'd3: sel_byte = rdata[31:24];
      default: sel_byte = rdata[7:0];
    endcase
    sel_half = addr[1] ? rdata[31:16] : rdata[15:0];

    ext = rdata;
    case (kind)
      LK_B:    ext = {{24{sel_byte[7]}}, sel_byte};
      LK_BU:   ext = {24'h000000, sel_byte};
      LK_H:    ext = {{16{sel_half[15]}}, sel_half};
      LK_HU:   ext = {16'h0000, sel_half};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/m_dm_ctrl.sv
// Memory-stage data-memory controller: request/grant/response bus FSM with pipeline stall.
// Define DM_ALIGN_CHK_EN to trap misaligned accesses as adel_m/ades_m instead of issuing them.
module m_dm_ctrl
  import mips_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   instr_m,
  input  logic [31:0]   ao_m,
  input  logic [DW-1:0] v2_m,
  input  logic [4:0]    a3_m,
  input  logic [1:0]    Tnew_m,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_m,
  output logic [DW-1:0] dm_rd_m,
  output logic          fwd_ok_m
`ifdef DM_ALIGN_CHK_EN
  ,
  output logic          adel_m,
  output logic          ades_m
`endif
);

  dm_state_t   state;
  logic [31:0] rdata_q;

  logic [5:0]  opcode;
  logic        is_load;
  logic        is_store;
  logic        misaligned;
  logic        mem_op;
  load_kind_t  kind;
  logic [3:0]  be_store;
  logic [31:0] wdata_store;
  logic [31:0] ext_data;

  assign opcode = instr_m[31:26];

  always_comb begin
    is_load     = 1'b0;
    is_store    = 1'b0;
    misaligned  = 1'b0;
    kind        = LK_W;
    be_store    = BE_WORD;
    wdata_store = v2_m;
    case (opcode)
      OP_LB:  begin is_load = 1'b1; kind = LK_B; end
      OP_LBU: begin is_load = 1'b1; kind = LK_BU; end
      OP_LH:  begin is_load = 1'b1; kind = LK_H;  misaligned = ao_m[0]; end
      OP_LHU: begin is_load = 1'b1; kind = LK_HU; misaligned = ao_m[0]; end
      OP_LW:  begin is_load = 1'b1; kind = LK_W;  misaligned = |ao_m[1:0]; end
      OP_SB: begin
        is_store    = 1'b1;
        be_store    = 4'b0001 << ao_m[1:0];
        wdata_store = {4{v2_m[7:0]}};
      end
      OP_SH: begin
        is_store    = 1'b1;
        be_store    = ao_m[1] ? BE_HI_HALF : BE_LO_HALF;
        wdata_store = {2{v2_m[15:0]}};
        misaligned  = ao_m[0];
      end
      OP_SW:  begin is_store = 1'b1; misaligned = |ao_m[1:0]; end
      default: ;
    endcase
  end

  // A trapped misaligned access behaves like a non-memory instruction.
`ifdef DM_ALIGN_CHK_EN
  assign mem_op = (is_load | is_store) & ~misaligned;
  assign adel_m = is_load & misaligned;
  assign ades_m = is_store & misaligned;
`else
  assign mem_op = is_load | is_store;
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
`endif

  logic unused_instr_bits;
  assign unused_instr_bits = ^instr_m[25:0];

  // DONE always returns to IDLE so each instruction gets its own grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rdata_q <= 32'h0;
    end else begin
      case (state)
        IDLE: if (mem_op && mem_gnt) state <= is_store ? DONE : WAIT;
        WAIT: if (mem_rvalid) begin
          rdata_q <= mem_rdata;
          state   <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  dm_ext u_ext (
    .rdata (rdata_q),
    .addr  (ao_m[1:0]),
    .kind  (kind),
    .ext   (ext_data)
  );

  always_comb begin
    mem_req   = (state == IDLE) && mem_op;
    stall_m   = (state == IDLE) ? mem_op : (state == WAIT);
    mem_we    = mem_req && is_store;
    mem_be    = mem_req ? (is_store ? be_store : BE_WORD) : 4'b0000;
    mem_wdata = (mem_req && is_store) ? wdata_store : '0;
    mem_addr  = mem_req ? {ao_m[AW-1:2], 2'b00} : '0;
    dm_rd_m   = ((state == DONE) && is_load) ? ext_data : '0;
    fwd_ok_m  = (Tnew_m == 2'd0) && !stall_m && (a3_m != 5'd0);
  end

endmodule
